// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues single-beat ibus requests and
// feeds the F/D register through an output slot backed by a one-entry skid buffer.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [63:0] PC_STEP  = 64'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_n;
    logic [63:0] pc, pc_n;
    logic [63:0] pend_pc, pend_pc_n;
    logic        buf_valid, buf_valid_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [63:0] buf_pc, buf_pc_n;
    logic        ireq_valid_n;
    logic [63:0] ireq_addr_n;
    logic        out_valid_n;
    logic [31:0] out_instr_n;
    logic [63:0] out_pc_n;

    logic [63:0] rd_pc;
    logic        slot_free;

    assign rd_pc     = redirect_pc & ~64'h3;
    assign slot_free = !out_valid || !stall;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pend_pc_n    = pend_pc;
        buf_valid_n  = buf_valid;
        buf_instr_n  = buf_instr;
        buf_pc_n     = buf_pc;
        ireq_valid_n = ireq_valid;
        ireq_addr_n  = ireq_addr;
        out_valid_n  = out_valid;
        out_instr_n  = out_instr;
        out_pc_n     = out_pc;

        if (out_valid && !stall)
            out_valid_n = 1'b0;

        if (redirect) begin
            out_valid_n = 1'b0;
            buf_valid_n = 1'b0;
            // An unanswered request must stay on the bus; park the target until it returns.
            if ((state == FETCH || state == DRAIN) && !iresp_data_ok) begin
                pend_pc_n = rd_pc;
                state_n   = DRAIN;
            end else begin
                ireq_valid_n = 1'b1;
                ireq_addr_n  = rd_pc;
                pc_n         = rd_pc + PC_STEP;
                state_n      = FETCH;
            end
        end else begin
            case (state)
                IDLE: begin
                    ireq_valid_n = 1'b1;
                    ireq_addr_n  = pc;
                    state_n      = FETCH;
                end
                FETCH: begin
                    if (iresp_data_ok) begin
                        pc_n = ireq_addr + PC_STEP;
                        if (slot_free) begin
                            out_valid_n = 1'b1;
                            out_instr_n = iresp_data;
                            out_pc_n    = ireq_addr;
                            ireq_addr_n = ireq_addr + PC_STEP;
                        end else begin
                            buf_valid_n  = 1'b1;
                            buf_instr_n  = iresp_data;
                            buf_pc_n     = ireq_addr;
                            ireq_valid_n = 1'b0;
                            state_n      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        out_valid_n  = 1'b1;
                        out_instr_n  = buf_instr;
                        out_pc_n     = buf_pc;
                        buf_valid_n  = 1'b0;
                        ireq_valid_n = 1'b1;
                        ireq_addr_n  = pc;
                        state_n      = FETCH;
                    end
                end
                DRAIN: begin
                    out_valid_n = 1'b0;
                    if (iresp_data_ok) begin
                        ireq_addr_n = pend_pc;
                        pc_n        = pend_pc + PC_STEP;
                        state_n     = FETCH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend_pc    <= '0;
            buf_valid  <= 1'b0;
            buf_instr  <= '0;
            buf_pc     <= '0;
            ireq_valid <= 1'b0;
            ireq_addr  <= '0;
            out_valid  <= 1'b0;
            out_instr  <= '0;
            out_pc     <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pend_pc    <= pend_pc_n;
            buf_valid  <= buf_valid_n;
            buf_instr  <= buf_instr_n;
            buf_pc     <= buf_pc_n;
            ireq_valid <= ireq_valid_n;
            ireq_addr  <= ireq_addr_n;
            out_valid  <= out_valid_n;
            out_instr  <= out_instr_n;
            out_pc     <= out_pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected deliveries are queued by the stimulus
// and a negedge monitor pops them whenever the output slot is consumed.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Drive a bus response for the address currently on the bus.
    task automatic resp(input logic ok);
        iresp_data_ok = ok;
        iresp_data    = ireq_addr[31:0];
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        iresp_data_ok = 1'b0; iresp_data = '0;
        cyc();
        cyc();
        chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
        chk("rst_ireq_addr", ireq_addr, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
        reset = 1'b0;
        cyc();
        chk("first_req_valid", {63'd0, ireq_valid}, 64'd1);
        chk("first_req_addr", ireq_addr, 64'h8000_0000);
    endtask

    // Scoreboard monitor: one pop per consumed output slot.
    always @(negedge clk) begin
        if (!reset && out_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out: got pc %h instr %h with nothing expected", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    failures++;
                    $display("FAIL out_slot: got pc %h instr %h expected pc %h instr %h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        // Back-to-back, zero-latency bus
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("b2b_addr", ireq_addr, 64'h8000_0000 + 64'(4 * i));
            resp(1'b1);
            push(64'h8000_0000 + 64'(4 * i), 32'h8000_0000 + 32'(4 * i));
            cyc();
            chk("b2b_out_valid", {63'd0, out_valid}, 64'd1);
        end
        resp(1'b0);
        cyc();

        // Response returns while the slot is full and stalled
        do_reset();
        resp(1'b1); push(64'h8000_0000, 32'h8000_0000);
        cyc();
        stall = 1'b1; resp(1'b1); push(64'h8000_0004, 32'h8000_0004);
        cyc();
        resp(1'b0);
        chk("hold_req_off1", {63'd0, ireq_valid}, 64'd0);
        chk("hold_out_pc", out_pc, 64'h8000_0000);
        cyc();
        chk("hold_req_off2", {63'd0, ireq_valid}, 64'd0);
        cyc();
        chk("hold_req_off3", {63'd0, ireq_valid}, 64'd0);
        stall = 1'b0;
        cyc();
        chk("hold_resume_valid", {63'd0, ireq_valid}, 64'd1);
        chk("hold_resume_addr", ireq_addr, 64'h8000_0008);
        chk("hold_out_pc_buf", out_pc, 64'h8000_0004);
        resp(1'b1); push(64'h8000_0008, 32'h8000_0008);
        cyc();
        resp(1'b0);
        cyc();

        // Redirect while a slow request is outstanding
        do_reset();
        cyc();
        redirect = 1'b1; redirect_pc = 64'h8000_0100;
        cyc();
        redirect = 1'b0;
        chk("drain_addr_held", ireq_addr, 64'h8000_0000);
        chk("drain_req_valid", {63'd0, ireq_valid}, 64'd1);
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
        cyc();
        resp(1'b1);
        cyc();
        chk("drain_drop_out", {63'd0, out_valid}, 64'd0);
        chk("drain_next_addr", ireq_addr, 64'h8000_0100);
        resp(1'b1); push(64'h8000_0100, 32'h8000_0100);
        cyc();
        resp(1'b0);
        cyc();

        // Latest redirect during drain wins
        do_reset();
        redirect = 1'b1; redirect_pc = 64'h8000_0200;
        cyc();
        redirect_pc = 64'h8000_0300;
        cyc();
        redirect = 1'b0; resp(1'b1);
        cyc();
        chk("two_redir_addr", ireq_addr, 64'h8000_0300);
        chk("two_redir_out", {63'd0, out_valid}, 64'd0);
        resp(1'b1); push(64'h8000_0300, 32'h8000_0300);
        cyc();
        resp(1'b0);
        cyc();

        // Redirect coincides with data_ok under stall; target low bits forced to 0
        do_reset();
        resp(1'b1);
        cyc();
        stall = 1'b1; resp(1'b1);
        redirect = 1'b1; redirect_pc = 64'h8000_0103;
        cyc();
        redirect = 1'b0; stall = 1'b0;
        chk("redir_ok_out", {63'd0, out_valid}, 64'd0);
        chk("redir_ok_addr", ireq_addr, 64'h8000_0100);
        chk("redir_ok_valid", {63'd0, ireq_valid}, 64'd1);
        resp(1'b1); push(64'h8000_0100, 32'h8000_0100);
        cyc();
        resp(1'b0);
        cyc();

        // Address wrap at the top of the 64-bit space
        do_reset();
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC; resp(1'b1);
        cyc();
        redirect = 1'b0;
        chk("wrap_addr0", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        resp(1'b1); push(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_addr1", ireq_addr, 64'h0);
        resp(1'b1); push(64'h0, 32'h0);
        cyc();
        resp(1'b0);
        cyc();

        // Reset mid-request, then a late data_ok
        do_reset();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_req", {63'd0, ireq_valid}, 64'd0);
        chk("mid_rst_out", {63'd0, out_valid}, 64'd0);
        iresp_data_ok = 1'b1; iresp_data = 32'hDEAD_BEEF;
        cyc();
        chk("mid_rst_restart", ireq_addr, 64'h8000_0000);
        chk("mid_rst_out2", {63'd0, out_valid}, 64'd0);
        resp(1'b1); push(64'h8000_0000, 32'h8000_0000);
        cyc();
        resp(1'b0);
        cyc();
        cyc();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch-stage sequencer between the PC and the instruction bus. It owns the PC and issues single-beat ibus requests. It presents fetched instructions to the F/D pipeline register through a one-entry output slot plus a one-entry skid buffer. Downstream stalls and branch/jump redirects are handled here; an in-flight request is never abandoned.

Parameters:
RESET_PC, 64'h8000_0000, PC loaded on reset
PC_STEP, 4, PC increment per fetched instruction

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  downstream cannot accept; out_* must hold
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  64  new fetch target; bits [1:0] forced to 0
ireq_valid  out  1  ibus request valid (registered)
ireq_addr  out  64  ibus request address (registered)
iresp_data_ok  in  1  ibus returns data this cycle
iresp_data  in  32  returned instruction
out_valid  out  1  out_instr/out_pc hold a real instruction
out_instr  out  32  instruction to F/D register
out_pc  out  64  PC of out_instr

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. All state updates occur on the posedge of clk.
- Reset values: state=IDLE, pc=RESET_PC, ireq_valid=0, ireq_addr=0, out_valid=0, out_instr=0, out_pc=0, buf_valid=0, pend_pc=0. A reset asserted mid-request drops the request: ireq_valid=0 on the next edge and any later data_ok for it is ignored.
- Consumption: the output slot is consumed on any cycle with out_valid && !stall. out_* are stable while out_valid && stall.
- Bus rule: once ireq_valid=1, ireq_addr stays constant until the cycle iresp_data_ok=1.
- IDLE (redirect=0): ireq_valid<=1, ireq_addr<=pc. Next state is FETCH. The first request is visible one cycle after reset deasserts.
- FETCH, data_ok=1, redirect=0:
  - If the slot is free or being consumed: out_valid<=1, out_instr<=iresp_data, out_pc<=ireq_addr. Then pc<=ireq_addr+PC_STEP, ireq_addr<=pc next, ireq_valid stays 1, state stays FETCH. This gives back-to-back throughput of 1 instruction per cycle when data_ok is returned in the request cycle.
  - Else (slot full and stalled): buf<=(data, addr), buf_valid<=1, ireq_valid<=0, pc<=addr+PC_STEP, state HOLD.
- FETCH, data_ok=0, redirect=0: hold the request.
- HOLD: no request is issued. When stall=0: out<=buf, buf_valid<=0, ireq_valid<=1, ireq_addr<=pc, state FETCH.
- Redirect has highest priority over stall and data:
  - Always: out_valid<=0, buf_valid<=0.
  - FETCH with data_ok=1, or IDLE/HOLD: discard any returned data, ireq_valid<=1, ireq_addr<=redirect_pc, pc<=redirect_pc+PC_STEP after issue, state FETCH.
  - FETCH with data_ok=0: pend_pc<=redirect_pc, keep the request stable, state DRAIN.
- DRAIN:
  - Request stays asserted. A new redirect overwrites pend_pc (latest wins).
  - On data_ok: discard the data, ireq_addr<=pend_pc, state FETCH. If redirect coincides with that data_ok, use redirect_pc instead.
  - out_valid stays 0 throughout DRAIN.
- Address arithmetic: 64-bit wraps modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC+4 -> 0). redirect_pc[1:0] is forced to 0.
- Invariants: never more than one outstanding request; ireq_valid=0 in HOLD; no instruction is delivered twice or out of order.

Test Plan:
- Reset then zero-latency bus (data_ok same cycle, instr=pc[31:0]) -> ireq_addr 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; out_pc follows one cycle behind; out_valid=1 continuously.
- Stall high for 3 cycles while a response returns with the slot full -> buffer captures it, ireq_valid=0 for the stall duration; after release out_pc advances 8000_0004 then 8000_0008 with no loss or duplicate.
- 3-cycle bus latency, redirect to 8000_0100 one cycle after the request -> ireq_addr held until data_ok, that data dropped (out_valid=0), next ireq_addr=8000_0100, then out_pc=8000_0100.
- Two redirects (0x200 then 0x300) during DRAIN -> the fetch after drain targets 8000_0300 only.
- Redirect coinciding with data_ok and stall=1 -> data discarded, out_valid=0 next cycle, ireq_addr=redirect_pc; redirect_pc=0x...103 is issued as 0x...100.
- Reset asserted while a request is outstanding, with a late data_ok -> ireq_valid=0, out_valid=0, then restart at 8000_0000; the late data is never output.
